// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared types, mode constants and digit-count helper for match_pair_seq
package match_pkg;

    // Controller states: wait for an operand pair, scan digits, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ways of combining the per-operand match flags
    localparam int MODE_AND = 0;
    localparam int MODE_OR  = 1;

    // Number of DIGIT-bit slices in a WIDTH-bit operand
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_eq.sv
// rtl/digit_eq.sv - DIGIT-bit slice equality comparator
//
// Ports:
//   a   in  DIGIT  operand slice
//   b   in  DIGIT  target slice
//   eq  out 1      1 when a equals b
module digit_eq #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/match_pair_seq.sv
// rtl/match_pair_seq.sv - digit-serial comparison of an operand pair against constant targets
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operand pair offered
//   in_ready   out 1      block can accept a pair (IDLE only)
//   x, y       in  WIDTH  operands, captured on accept
//   out_valid  out 1      result available (DONE only)
//   out_ready  in  1      consumer takes the result
//   out        out 1      (x==TARGET_X) AND/OR (y==TARGET_Y), per MODE
//   hit_count  out CNT_W  saturating count of delivered results equal to 1
module match_pair_seq
    import match_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DIGIT      = 8,
    parameter logic [WIDTH-1:0] TARGET_X   = WIDTH'(9001),
    parameter logic [WIDTH-1:0] TARGET_Y   = WIDTH'(1337),
    parameter int               MODE       = MODE_AND,
    parameter int               CONST_TIME = 1,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic [CNT_W-1:0] hit_count
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int DW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("match_pair_seq: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [DW-1:0]      d_q, d_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               eq_x_q, eq_x_d;
    logic               eq_y_q, eq_y_d;
    logic [CNT_W-1:0]   hit_q, hit_d;

    logic [DIGIT-1:0]   x_slice, y_slice, tx_slice, ty_slice;
    logic               x_dig_eq, y_dig_eq;
    logic               eq_x_upd, eq_y_upd;
    logic               decided;
    logic               result;

    // Slice selection lives here so digit_eq stays a pure comparator
    always_comb begin
        x_slice  = x_q[int'(d_q)*DIGIT +: DIGIT];
        y_slice  = y_q[int'(d_q)*DIGIT +: DIGIT];
        tx_slice = TARGET_X[int'(d_q)*DIGIT +: DIGIT];
        ty_slice = TARGET_Y[int'(d_q)*DIGIT +: DIGIT];
    end

    digit_eq #(.DIGIT(DIGIT)) u_eq_x (
        .a  (x_slice),
        .b  (tx_slice),
        .eq (x_dig_eq)
    );

    digit_eq #(.DIGIT(DIGIT)) u_eq_y (
        .a  (y_slice),
        .b  (ty_slice),
        .eq (y_dig_eq)
    );

    always_comb begin
        eq_x_upd = eq_x_q & x_dig_eq;
        eq_y_upd = eq_y_q & y_dig_eq;
        // Result is settled once no remaining digit can turn it back to 1
        if (MODE == MODE_OR) begin
            decided = ~eq_x_upd & ~eq_y_upd;
            result  = eq_x_q | eq_y_q;
        end else begin
            decided = ~eq_x_upd | ~eq_y_upd;
            result  = eq_x_q & eq_y_q;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        x_d     = x_q;
        y_d     = y_q;
        eq_x_d  = eq_x_q;
        eq_y_d  = eq_y_q;
        hit_d   = hit_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    d_d     = '0;
                    eq_x_d  = 1'b1;
                    eq_y_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                eq_x_d = eq_x_upd;
                eq_y_d = eq_y_upd;
                d_d    = d_q + DW'(1);
                // Early exit is suppressed when CONST_TIME is set so latency is data-independent
                if (d_q == DW'(N-1) || (CONST_TIME == 0 && decided)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (result && hit_q != {CNT_W{1'b1}}) begin
                        hit_d = hit_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            eq_x_q  <= 1'b0;
            eq_y_q  <= 1'b0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            x_q     <= x_d;
            y_q     <= y_d;
            eq_x_q  <= eq_x_d;
            eq_y_q  <= eq_y_d;
            hit_q   <= hit_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = (state_q == DONE) & result;
    assign hit_count = hit_q;

endmodule
